// File: rtl/clap_sequencer_if.sv
// rtl/clap_sequencer_if.sv - energy stream handshake between energy stage and clap sequencer
//
// Signals:
//   energy_data   unsigned energy word, ENERGY_WIDTH bits
//   energy_valid  energy word valid
//   energy_ready  consumer accepts energy
// Modports:
//   master  energy producer (drives data/valid, observes ready)
//   slave   clap sequencer (observes data/valid, drives ready)

interface clap_sequencer_if #(
    parameter int ENERGY_WIDTH = 37
);
    logic [ENERGY_WIDTH-1:0] energy_data;
    logic                    energy_valid;
    logic                    energy_ready;

    modport master (
        output energy_data,
        output energy_valid,
        input  energy_ready
    );

    modport slave (
        input  energy_data,
        input  energy_valid,
        output energy_ready
    );
endinterface

// File: rtl/clap_sequencer.sv
// rtl/clap_sequencer.sv - double-clap detector that toggles a light state from an energy stream
//
// Ports:
//   clock          single clock
//   nreset         synchronous active-low reset
//   energy         energy stream (slave side of clap_sequencer_if)
//   threshold      unsigned trip level, sampled every cycle
//   toglite_state  light state, toggles on each detected double-clap
//   clap_pulse     one-cycle strobe per detected double-clap
//   state_dbg      current state: IDLE=0 CLAP1=1 GAP=2 CLAP2=3 HOLDOFF=4

module clap_sequencer #(
    parameter int ENERGY_WIDTH    = 37,
    parameter int MAX_CLAP_CYCLES = 5_000_000,
    parameter int MIN_GAP_CYCLES  = 5_000_000,
    parameter int MAX_GAP_CYCLES  = 40_000_000,
    parameter int HOLDOFF_CYCLES  = 25_000_000
) (
    input  logic                    clock,
    input  logic                    nreset,
    clap_sequencer_if.slave         energy,
    input  logic [ENERGY_WIDTH-1:0] threshold,
    output logic                    toglite_state,
    output logic                    clap_pulse,
    output logic [2:0]              state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLAP1   = 3'd1,
        GAP     = 3'd2,
        CLAP2   = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    // Timeout L fires on the last cycle of an L-cycle stay (timer == L-1).
    localparam logic [31:0] CLAP_LAST    = 32'(MAX_CLAP_CYCLES - 1);
    localparam logic [31:0] GAP_LAST     = 32'(MAX_GAP_CYCLES - 1);
    localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);
    localparam logic [31:0] GAP_MIN      = 32'(MIN_GAP_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [31:0] timer;
    logic        ready_q;
    logic        toggle_q;
    logic        pulse_q;
    logic        do_toggle;
    logic        accepted;
    logic        hi;
    logic        lo;

    assign energy.energy_ready = ready_q;
    assign toglite_state       = toggle_q;
    assign clap_pulse          = pulse_q;
    assign state_dbg           = state;

    // Events only exist on accepted beats; between the two levels is the
    // hysteresis band, which produces neither event.
    assign accepted = energy.energy_valid & ready_q;
    assign hi       = accepted & (energy.energy_data > threshold);
    assign lo       = accepted & (energy.energy_data < (threshold >> 1));

    // Events are tested before timeouts so an event on the final timer
    // cycle still wins.
    always_comb begin
        next_state = state;
        do_toggle  = 1'b0;
        case (state)
            IDLE: begin
                if (hi) next_state = CLAP1;
            end
            CLAP1: begin
                if (lo)                      next_state = GAP;
                else if (timer == CLAP_LAST) next_state = HOLDOFF;
            end
            GAP: begin
                // A burst that arrives too early is treated as a fresh first clap.
                if (hi)                     next_state = (timer >= GAP_MIN) ? CLAP2 : CLAP1;
                else if (timer == GAP_LAST) next_state = IDLE;
            end
            CLAP2: begin
                if (lo) begin
                    next_state = HOLDOFF;
                    do_toggle  = 1'b1;
                end else if (timer == CLAP_LAST) begin
                    next_state = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (timer == HOLDOFF_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state    <= IDLE;
            timer    <= '0;
            ready_q  <= 1'b0;
            toggle_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state    <= next_state;
            // The first cycle in any state always sees timer == 0, including
            // a GAP -> CLAP1 restart.
            timer    <= (next_state != state) ? 32'd0 : timer + 32'd1;
            ready_q  <= 1'b1;
            pulse_q  <= do_toggle;
            if (do_toggle) toggle_q <= ~toggle_q;
        end
    end

endmodule

// File: tb/tb_clap_sequencer.sv
// tb/tb_clap_sequencer.sv - directed self-checking bench for clap_sequencer

module tb_clap_sequencer;

    localparam int EW = 37;

    logic          clock = 1'b0;
    logic          nreset;
    logic [EW-1:0] threshold;
    logic          toglite_state;
    logic          clap_pulse;
    logic [2:0]    state_dbg;

    clap_sequencer_if #(.ENERGY_WIDTH(EW)) energy_bus ();

    clap_sequencer #(
        .ENERGY_WIDTH    (EW),
        .MAX_CLAP_CYCLES (8),
        .MIN_GAP_CYCLES  (4),
        .MAX_GAP_CYCLES  (16),
        .HOLDOFF_CYCLES  (6)
    ) dut (
        .clock         (clock),
        .nreset        (nreset),
        .energy        (energy_bus),
        .threshold     (threshold),
        .toglite_state (toglite_state),
        .clap_pulse    (clap_pulse),
        .state_dbg     (state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       tog;
        logic       pulse;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic tog_m    = 1'b0;

    localparam logic [2:0] S_IDLE = 3'd0, S_C1 = 3'd1, S_GAP = 3'd2, S_C2 = 3'd3, S_HO = 3'd4;

    task automatic check1(input string tag, input string what, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s %s observed=%0d expected=%0d", tag, what, obs, exp);
        end
    endtask

    // One clock: drive a beat, queue the outputs expected after the edge,
    // then pop and compare once the DUT has registered them.
    task automatic cyc(input logic v, input logic [EW-1:0] d, input logic [2:0] st,
                       input logic pulse, input logic rdy, input string tag);
        exp_t e;
        energy_bus.energy_valid = v;
        energy_bus.energy_data  = d;
        e.tag = tag; e.st = st; e.tog = tog_m; e.pulse = pulse; e.rdy = rdy;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check1(e.tag, "state_dbg",     state_dbg,                    e.st);
        check1(e.tag, "toglite_state", {2'b00, toglite_state},       {2'b00, e.tog});
        check1(e.tag, "clap_pulse",    {2'b00, clap_pulse},          {2'b00, e.pulse});
        check1(e.tag, "energy_ready",  {2'b00, energy_bus.energy_ready}, {2'b00, e.rdy});
    endtask

    task automatic holdoff(input string tag);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, S_HO, 1'b0, 1'b1, tag);
        cyc(1'b0, '0, S_IDLE, 1'b0, 1'b1, {tag, "_end"});
    endtask

    task automatic double_clap(input string tag);
        cyc(1'b1, 37'd2000, S_C1,  1'b0, 1'b1, {tag, "_hi1"});
        cyc(1'b1, 37'd100,  S_GAP, 1'b0, 1'b1, {tag, "_lo1"});
        for (int i = 0; i < 5; i++) cyc(1'b1, 37'd100, S_GAP, 1'b0, 1'b1, {tag, "_gap"});
        cyc(1'b1, 37'd2000, S_C2,  1'b0, 1'b1, {tag, "_hi2"});
        tog_m = ~tog_m;
        cyc(1'b1, 37'd100,  S_HO,  1'b1, 1'b1, {tag, "_lo2"});
        holdoff({tag, "_holdoff"});
    endtask

    initial begin
        nreset                  = 1'b0;
        threshold               = 37'd1000;
        energy_bus.energy_valid = 1'b0;
        energy_bus.energy_data  = '0;

        // Reset held with a hi beat offered: nothing may be accepted.
        for (int i = 0; i < 3; i++) cyc(1'b1, 37'd2000, S_IDLE, 1'b0, 1'b0, "reset");
        nreset = 1'b1;
        cyc(1'b1, 37'd2000, S_IDLE, 1'b0, 1'b1, "release");

        // Equal to threshold is not hi; invalid beats are ignored.
        cyc(1'b1, 37'd1000, S_IDLE, 1'b0, 1'b1, "equal_threshold");
        cyc(1'b0, 37'd2000, S_IDLE, 1'b0, 1'b1, "invalid_hi");

        double_clap("dclap_a");
        double_clap("dclap_b");

        // Gap too short restarts as a first clap, then sustained 500 (band) times out.
        cyc(1'b1, 37'd2000, S_C1,  1'b0, 1'b1, "short_hi1");
        cyc(1'b1, 37'd100,  S_GAP, 1'b0, 1'b1, "short_lo1");
        cyc(1'b0, '0,       S_GAP, 1'b0, 1'b1, "short_gap0");
        cyc(1'b0, '0,       S_GAP, 1'b0, 1'b1, "short_gap1");
        cyc(1'b1, 37'd2000, S_C1,  1'b0, 1'b1, "short_rehi");
        for (int i = 0; i < 7; i++) cyc(1'b1, 37'd500, S_C1, 1'b0, 1'b1, "noise_hold");
        cyc(1'b1, 37'd500, S_HO, 1'b0, 1'b1, "noise_timeout");
        holdoff("noise_holdoff");

        // Gap too long: lo-level beats in GAP are ignored, 16 cycles to IDLE.
        cyc(1'b1, 37'd2000, S_C1,  1'b0, 1'b1, "long_hi1");
        cyc(1'b1, 37'd100,  S_GAP, 1'b0, 1'b1, "long_lo1");
        for (int i = 0; i < 15; i++) cyc(1'b1, '0, S_GAP, 1'b0, 1'b1, "long_gap");
        cyc(1'b1, '0, S_IDLE, 1'b0, 1'b1, "long_timeout");

        double_clap("dclap_c");

        // hi on the last GAP cycle beats the timeout; reset in CLAP2 clears all.
        cyc(1'b1, 37'd2000, S_C1,  1'b0, 1'b1, "edge_hi1");
        cyc(1'b1, 37'd100,  S_GAP, 1'b0, 1'b1, "edge_lo1");
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, S_GAP, 1'b0, 1'b1, "edge_gap");
        cyc(1'b1, 37'd2000, S_C2, 1'b0, 1'b1, "edge_priority");
        nreset = 1'b0;
        tog_m  = 1'b0;
        cyc(1'b1, 37'd100, S_IDLE, 1'b0, 1'b0, "reset_in_clap2");
        nreset = 1'b1;
        cyc(1'b0, '0, S_IDLE, 1'b0, 1'b1, "release2");

        // threshold 0: nonzero is hi, lo never happens, CLAP1 must time out.
        threshold = '0;
        cyc(1'b1, 37'd1, S_C1, 1'b0, 1'b1, "thr0_hi");
        for (int i = 0; i < 7; i++) cyc(1'b1, '0, S_C1, 1'b0, 1'b1, "thr0_hold");
        cyc(1'b1, '0, S_HO, 1'b0, 1'b1, "thr0_timeout");
        holdoff("thr0_holdoff");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
